syzygy_adc_tx_framer: RTL and testbench

Fabric-side transmit framer for the SYZYGY two-lane LVDS ADC link, acting as an ADC emulator. It produces, on every `slow_clk` cycle, the 8-bit parallel words that feed the frame OSERDES and two data-lane OSERDES. The frame lane carries the `8'hF0` pattern, which the receive side bit-slips against. The block buffers 16-bit samples from a valid/ready source, emits a training period on enable or on request, and reports underflow.

---
 rtl/syzygy_adc_tx_framer.sv | 154 +++++++++++++++
 tb/tb_syzygy_adc_tx_framer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_adc_tx_framer.sv
// syzygy_adc_tx_framer: fabric-side SYZYGY ADC emulator transmit framer.
// Produces the frame (F0) and two data lane words for the OSERDES on every
// slow_clk cycle. Samples are buffered in a small FIFO.
// Optional feature: define SYZYGY_ADC_TX_PRBS_EN to add the prbs_sel port and
// a PRBS-7 lane generator.
module syzygy_adc_tx_framer #(
    parameter int TRAIN_CYCLES = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        slow_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        train_req,
    input  logic [15:0] s_data,
    input  logic        s_valid,
`ifdef SYZYGY_ADC_TX_PRBS_EN
    input  logic        prbs_sel,
`endif
    output logic        s_ready,
    output logic [7:0]  frame_word,
    output logic [7:0]  lane0_word,
    output logic [7:0]  lane1_word,
    output logic        word_valid,
    output logic        training,
    output logic [15:0] underflow_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic            fifo_empty, full_n, push, pop, flush, prbs_on;
    logic [15:0]     prbs_word;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign push       = s_valid & s_ready;

`ifdef SYZYGY_ADC_TX_PRBS_EN
    logic [6:0] lfsr, lfsr_n;

    // Advance the x^7+x^6+1 generator 16 bits; first generated bit lands in word[15].
    always_comb begin
        lfsr_n    = lfsr;
        prbs_word = '0;
        for (int i = 0; i < 16; i++) begin
            prbs_word[15-i] = lfsr_n[6] ^ lfsr_n[5];
            lfsr_n          = {lfsr_n[5:0], lfsr_n[6] ^ lfsr_n[5]};
        end
    end

    // Generator is held at seed outside RUN, so every TRAIN/IDLE entry reseeds it.
    always_ff @(posedge slow_clk) begin
        if (!reset_n)            lfsr <= 7'h7F;
        else if (state_n != RUN) lfsr <= 7'h7F;
        else if (prbs_on)        lfsr <= lfsr_n;
    end
`else
    assign prbs_word = '0;
`endif

    // Next-state, FIFO pointer and pop decisions; outputs are registered from these.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        flush   = 1'b0;
        prbs_on = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = TRAIN;
                    cnt_n   = CW'(TRAIN_CYCLES);
                end
            end
            TRAIN: begin
                if (!enable) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (train_req) begin
                    cnt_n = CW'(TRAIN_CYCLES);
                end else if (cnt == CW'(1)) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (train_req) begin
                    state_n = TRAIN;
                    cnt_n   = CW'(TRAIN_CYCLES);
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef SYZYGY_ADC_TX_PRBS_EN
        prbs_on = (state_n == RUN) & prbs_sel;
`endif
        // Outputs describe the cycle being entered, so the pop follows state_n.
        pop      = (state_n == RUN) & ~fifo_empty & ~prbs_on;
        wr_ptr_n = flush ? '0 : wr_ptr + (AW+1)'(push);
        rd_ptr_n = flush ? '0 : rd_ptr + (AW+1)'(pop);
        full_n   = ((wr_ptr_n ^ rd_ptr_n) == {1'b1, {AW{1'b0}}});
    end

    // Sample storage; no reset needed since pointers define validity.
    always_ff @(posedge slow_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_data;
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge slow_clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            s_ready         <= 1'b0;
            frame_word      <= 8'h00;
            lane0_word      <= 8'h00;
            lane1_word      <= 8'h00;
            word_valid      <= 1'b0;
            training        <= 1'b0;
            underflow_count <= 16'h0000;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            s_ready    <= (state_n != IDLE) & ~full_n;
            training   <= (state_n == TRAIN);
            frame_word <= (state_n == IDLE) ? 8'h00 : 8'hF0;
            word_valid <= pop | prbs_on;
            case (state_n)
                TRAIN: {lane0_word, lane1_word} <= 16'hA55A;
                RUN: begin
                    if (prbs_on)  {lane0_word, lane1_word} <= prbs_word;
                    else if (pop) {lane0_word, lane1_word} <= mem[rd_ptr[AW-1:0]];
                    else          {lane0_word, lane1_word} <= 16'h0000;
                end
                default: {lane0_word, lane1_word} <= 16'h0000;
            endcase
            if ((state_n == RUN) && !prbs_on && fifo_empty && (underflow_count != 16'hFFFF))
                underflow_count <= underflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_syzygy_adc_tx_framer.sv
// Bench for syzygy_adc_tx_framer (TRAIN_CYCLES=4, FIFO_DEPTH=4).
// Accepted samples are queued; a negedge monitor pops and compares lane words.
module tb_syzygy_adc_tx_framer;

    logic        slow_clk = 1'b0;
    logic        reset_n, enable, train_req, s_valid;
    logic [15:0] s_data;
    logic        s_ready, word_valid, training;
    logic [7:0]  frame_word, lane0_word, lane1_word;
    logic [15:0] underflow_count;
`ifdef SYZYGY_ADC_TX_PRBS_EN
    logic        prbs_sel = 1'b0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] q[$];
    bit          prbs_mode = 1'b0;
    bit          a;
    int          accepted;

    always #5 slow_clk = ~slow_clk;

    syzygy_adc_tx_framer #(.TRAIN_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .slow_clk        (slow_clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .train_req       (train_req),
        .s_data          (s_data),
        .s_valid         (s_valid),
`ifdef SYZYGY_ADC_TX_PRBS_EN
        .prbs_sel        (prbs_sel),
`endif
        .s_ready         (s_ready),
        .frame_word      (frame_word),
        .lane0_word      (lane0_word),
        .lane1_word      (lane1_word),
        .word_valid      (word_valid),
        .training        (training),
        .underflow_count (underflow_count)
    );

    // Scoreboard: every valid lane word must be the oldest accepted sample.
    always @(negedge slow_clk) begin
        if (reset_n === 1'b1 && word_valid === 1'b1 && !prbs_mode) begin
            logic [15:0] exp;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra got=%h exp=none", {lane0_word, lane1_word});
            end else begin
                exp = q.pop_front();
                if ({lane0_word, lane1_word} !== exp) begin
                    failures++;
                    $display("FAIL scoreboard_word got=%h exp=%h", {lane0_word, lane1_word}, exp);
                end
            end
        end
    end

    // One clock edge; records an accepted sample and returns 1 ns after the edge.
    task automatic tick(output bit acc);
        logic [15:0] d;
        acc = s_valid && s_ready && reset_n;
        d   = s_data;
        @(posedge slow_clk);
        if (acc) q.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_data = '0;
        tick(a); tick(a);
        checks++;
        if ({frame_word, lane0_word, lane1_word, word_valid, training, s_ready} !== 27'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {frame_word, lane0_word, lane1_word, word_valid, training, s_ready});
        end
        checks++;
        if (underflow_count !== 16'h0) begin
            failures++; $display("FAIL reset_underflow got=%h exp=0", underflow_count);
        end
        reset_n = 1'b1;
        tick(a);
        checks++;
        if ({frame_word, training} !== 9'h0) begin
            failures++; $display("FAIL idle_hold got=%h exp=0", {frame_word, training});
        end
    endtask

    task automatic test_train();
        enable = 1'b1;
        tick(a);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({training, frame_word, lane0_word, lane1_word, word_valid} !== {1'b1, 8'hF0, 8'hA5, 8'h5A, 1'b0}) begin
                failures++;
                $display("FAIL train_cycle%0d got=%h exp=%h", i,
                         {training, frame_word, lane0_word, lane1_word, word_valid},
                         {1'b1, 8'hF0, 8'hA5, 8'h5A, 1'b0});
            end
            tick(a);
        end
        checks++;
        if ({training, frame_word, word_valid, s_ready} !== {1'b0, 8'hF0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL run_entry got=%h exp=%h", {training, frame_word, word_valid, s_ready},
                     {1'b0, 8'hF0, 1'b0, 1'b1});
        end
        checks++;
        if (underflow_count !== 16'd1) begin
            failures++; $display("FAIL run_entry_underflow got=%h exp=1", underflow_count);
        end
    endtask

    task automatic test_single();
        s_data = 16'h1234; s_valid = 1'b1;
        tick(a);
        s_valid = 1'b0;
        checks++;
        if ({word_valid, underflow_count} !== {1'b0, 16'd2}) begin
            failures++; $display("FAIL latency_n got=%h exp=%h", {word_valid, underflow_count}, {1'b0, 16'd2});
        end
        tick(a);
        checks++;
        if ({word_valid, lane0_word, lane1_word, underflow_count} !== {1'b1, 8'h12, 8'h34, 16'd2}) begin
            failures++;
            $display("FAIL latency_n2 got=%h exp=%h", {word_valid, lane0_word, lane1_word, underflow_count},
                     {1'b1, 8'h12, 8'h34, 16'd2});
        end
        tick(a);
        checks++;
        if ({word_valid, lane0_word, lane1_word, underflow_count} !== {1'b0, 16'h0000, 16'd3}) begin
            failures++;
            $display("FAIL underflow_idle got=%h exp=%h", {word_valid, lane0_word, lane1_word, underflow_count},
                     {1'b0, 16'h0000, 16'd3});
        end
    endtask

    task automatic test_fill();
        accepted = 0;
        s_valid = 1'b1; s_data = 16'hA000; train_req = 1'b1;
        tick(a);
        train_req = 1'b0;
        if (a) begin accepted++; s_data++; end
        for (int i = 0; i < 8 && s_ready; i++) begin
            tick(a);
            if (a) begin accepted++; s_data++; end
        end
        s_valid = 1'b0;
        checks++;
        if ({accepted, s_ready, training} !== {32'd4, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fill_count got=%0d/%b/%b exp=4/0/1", accepted, s_ready, training);
        end
        for (int i = 0; i < 6; i++) tick(a);
        checks++;
        if ({q.size(), word_valid} !== {32'd0, 1'b0}) begin
            failures++; $display("FAIL fill_drain got=%0d left exp=0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 16'hB000 + 16'(i);
            tick(a);
            if (i >= 1) begin
                checks++;
                if (word_valid !== 1'b1) begin
                    failures++; $display("FAIL b2b_bubble%0d got=%b exp=1", i, word_valid);
                end
            end
        end
        s_valid = 1'b0;
        tick(a);
        checks++;
        if (word_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_last got=%b exp=1", word_valid);
        end
        tick(a);
        checks++;
        if ({word_valid, q.size()} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL b2b_end got=%b/%0d exp=0/0", word_valid, q.size());
        end
    endtask

    task automatic test_saturate();
        s_valid = 1'b0;
        repeat (65540) tick(a);
        checks++;
        if (underflow_count !== 16'hFFFF) begin
            failures++; $display("FAIL underflow_sat got=%h exp=ffff", underflow_count);
        end
        tick(a);
        checks++;
        if (underflow_count !== 16'hFFFF) begin
            failures++; $display("FAIL underflow_sat_hold got=%h exp=ffff", underflow_count);
        end
    endtask

    task automatic test_abort();
        s_valid = 1'b1; s_data = 16'hD000; train_req = 1'b1;
        tick(a);
        train_req = 1'b0;
        if (a) s_data++;
        for (int i = 0; i < 8 && s_ready; i++) begin
            tick(a);
            if (a) s_data++;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 10 && training; i++) tick(a);
        checks++;
        if (training !== 1'b0) begin
            failures++; $display("FAIL abort_reach_run got=%b exp=0", training);
        end
        enable = 1'b0; train_req = 1'b1;
        tick(a);
        q.delete();
        train_req = 1'b0;
        checks++;
        if ({frame_word, lane0_word, lane1_word, word_valid, training, s_ready} !== 27'h0) begin
            failures++;
            $display("FAIL abort_idle got=%h exp=0",
                     {frame_word, lane0_word, lane1_word, word_valid, training, s_ready});
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick(a);
        checks++;
        if ({training, word_valid, underflow_count} !== {1'b0, 1'b0, 16'hFFFF}) begin
            failures++;
            $display("FAIL abort_flushed got=%h exp=%h", {training, word_valid, underflow_count},
                     {1'b0, 1'b0, 16'hFFFF});
        end
    endtask

`ifdef SYZYGY_ADC_TX_PRBS_EN
    task automatic test_prbs();
        logic [6:0]  s;
        logic [15:0] w [2];
        s = 7'h7F;
        for (int k = 0; k < 2; k++)
            for (int b = 15; b >= 0; b--) begin
                w[k][b] = s[6] ^ s[5];
                s = {s[5:0], s[6] ^ s[5]};
            end
        s_valid = 1'b1; s_data = 16'hC000; train_req = 1'b1;
        tick(a);
        train_req = 1'b0; s_data = 16'hC001;
        tick(a);
        s_valid = 1'b0; prbs_sel = 1'b1; prbs_mode = 1'b1;
        for (int i = 0; i < 10 && training; i++) tick(a);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({word_valid, lane0_word, lane1_word} !== {1'b1, w[k]}) begin
                failures++;
                $display("FAIL prbs_word%0d got=%h exp=%h", k, {word_valid, lane0_word, lane1_word}, {1'b1, w[k]});
            end
            if (k == 0) tick(a);
        end
        prbs_sel = 1'b0;
        tick(a);
        prbs_mode = 1'b0;
        tick(a); tick(a);
        checks++;
        if ({q.size(), underflow_count} !== {32'd0, 16'hFFFF}) begin
            failures++; $display("FAIL prbs_fifo_kept got=%0d left exp=0", q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_train();
        test_single();
        test_fill();
        test_back_to_back();
        test_saturate();
        test_abort();
`ifdef SYZYGY_ADC_TX_PRBS_EN
        test_prbs();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
